// File: rtl/selector_41_pkg.sv
// selector_41_pkg: shared constants for the 4-to-1 data selector.
// Holds the select encoding and the default data width used by the
// interface, the combinational mux and the top level.
package selector_41_pkg;

   // Default width of each data channel and of both data outputs.
   localparam int unsigned DEF_WIDTH = 4;

   // Two-bit select as formed by {iS1, iS0}.
   typedef logic [1:0] sel_t;

   // Select encoding: which channel reaches the output.
   localparam sel_t SEL_C0 = 2'b00;
   localparam sel_t SEL_C1 = 2'b01;
   localparam sel_t SEL_C2 = 2'b10;
   localparam sel_t SEL_C3 = 2'b11;

   // Pack the two select pins into one select word, MSB first.
   function automatic sel_t make_sel(input logic s1, input logic s0);
      return {s1, s0};
   endfunction

endpackage : selector_41_pkg

// File: rtl/selector_41_if.sv
// selector_41_if: data/select bundle of the selector.
// The master side drives the four channels and the two select pins and
// observes the outputs; the slave side is the selector itself.
// There is no valid/ready handshake: channels and select are sampled
// continuously by the combinational path and on every rising clock edge
// by the registered path.
interface selector_41_if
   import selector_41_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);

   logic [WIDTH-1:0] iC0;
   logic [WIDTH-1:0] iC1;
   logic [WIDTH-1:0] iC2;
   logic [WIDTH-1:0] iC3;
   logic             iS1;
   logic             iS0;
   logic [WIDTH-1:0] oZ;
   logic [WIDTH-1:0] oZR;
   logic             oSelChg;

   // Stimulus / consumer side.
   modport master (
      output iC0, iC1, iC2, iC3, iS1, iS0,
      input  oZ, oZR, oSelChg
   );

   // Selector side.
   modport slave (
      input  iC0, iC1, iC2, iC3, iS1, iS0,
      output oZ, oZR, oSelChg
   );

endinterface : selector_41_if

// File: rtl/selector_41_mux4_comb.sv
// mux4_comb: purely combinational 4-to-1 selector.
// Only the channel named by sel_i reaches z_o; an unknown select drives
// all-X so that bad selects are visible in simulation instead of being
// silently mapped onto some channel.
module mux4_comb
   import selector_41_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  sel_t             sel_i,
   input  logic [WIDTH-1:0] c0_i,
   input  logic [WIDTH-1:0] c1_i,
   input  logic [WIDTH-1:0] c2_i,
   input  logic [WIDTH-1:0] c3_i,
   output logic [WIDTH-1:0] z_o
);

   // Route the selected channel; no priority default for unknown selects.
   always_comb begin
      z_o = {WIDTH{1'bx}};
      case (sel_i)
         SEL_C0:  z_o = c0_i;
         SEL_C1:  z_o = c1_i;
         SEL_C2:  z_o = c2_i;
         SEL_C3:  z_o = c3_i;
         default: z_o = {WIDTH{1'bx}};
      endcase
   end

endmodule : mux4_comb

// File: rtl/selector_41.sv
// selector_41: 4-to-1 data selector with a registered output copy and a
// select-change strobe.
// oZ is combinational (zero latency). oZR is oZ delayed by one rising edge.
// oSelChg pulses for one cycle when the select sampled at an edge differs
// from the one sampled at the previous edge; after reset the previous
// select is taken as 00.
module selector_41
   import selector_41_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic          iClk,
   input  logic          iRst,
   selector_41_if.slave  bus
);

   sel_t             sel_d;
   sel_t             sel_q;
   logic [WIDTH-1:0] z;
   logic [WIDTH-1:0] zr_d;
   logic [WIDTH-1:0] zr_q;
   logic             sel_chg_d;
   logic             sel_chg_q;

   mux4_comb #(
      .WIDTH (WIDTH)
   ) u_mux (
      .sel_i (sel_d),
      .c0_i  (bus.iC0),
      .c1_i  (bus.iC1),
      .c2_i  (bus.iC2),
      .c3_i  (bus.iC3),
      .z_o   (z)
   );

   // Next-state values: capture the live output, the live select, and
   // whether that select differs from the last captured one.
   always_comb begin
      sel_d     = make_sel(bus.iS1, bus.iS0);
      zr_d      = z;
      sel_chg_d = (sel_d != sel_q);
   end

   // Output register, select history and change strobe; reset clears
   // all three immediately.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         zr_q      <= '0;
         sel_q     <= SEL_C0;
         sel_chg_q <= 1'b0;
      end else begin
         zr_q      <= zr_d;
         sel_q     <= sel_d;
         sel_chg_q <= sel_chg_d;
      end
   end

   assign bus.oZ      = z;
   assign bus.oZR     = zr_q;
   assign bus.oSelChg = sel_chg_q;

endmodule : selector_41

// File: tb/tb_selector_41.sv
// tb_selector_41: directed bench for selector_41 with hand-computed
// expectations, a small expected-value queue for the registered output,
// and a single summary line at the end.
module tb_selector_41;
   import selector_41_pkg::*;

   localparam int unsigned W = 4;

   logic iClk;
   logic iRst;
   logic clk_en;

   int n_checks;
   int n_fail;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] chan [4];
   logic [W-1:0] exp_z;
   logic [W-1:0] exp_zr;
   logic [1:0]   cur_sel;
   logic [1:0]   prev_sel;

   selector_41_if #(.WIDTH(W)) bus ();

   selector_41 #(
      .WIDTH (W)
   ) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus)
   );

   // Clock: held low until enabled so the first tests see no edges.
   initial iClk = 1'b0;
   always begin
      #5;
      if (clk_en) iClk = ~iClk;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] sel, input logic [W-1:0] c0, input logic [W-1:0] c1,
                        input logic [W-1:0] c2, input logic [W-1:0] c3);
      bus.iS1 = sel[1];
      bus.iS0 = sel[0];
      bus.iC0 = c0;
      bus.iC1 = c1;
      bus.iC2 = c2;
      bus.iC3 = c3;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clk_en   = 1'b0;
      iRst     = 1'b1;
      drive(2'b00, 4'h0, 4'h0, 4'h0, 4'h0);

      // Reset state, no clock edge ever seen.
      #10;
      check_eq("reset_ozr", 32'(bus.oZR), 32'h0);
      check_eq("reset_selchg", 32'(bus.oSelChg), 32'h0);

      // Each channel alone, no clock.
      drive(2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000); #10;
      check_eq("route_c0", 32'(bus.oZ), 32'b0001);
      drive(2'b01, 4'b0000, 4'b0010, 4'b0000, 4'b0000); #10;
      check_eq("route_c1", 32'(bus.oZ), 32'b0010);
      drive(2'b10, 4'b0000, 4'b0000, 4'b0100, 4'b0000); #10;
      check_eq("route_c2", 32'(bus.oZ), 32'b0100);
      drive(2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b1000); #10;
      check_eq("route_c3", 32'(bus.oZ), 32'b1000);

      // Isolation: unselected channels toggle, oZ must hold 1010.
      drive(2'b10, 4'b0000, 4'b0000, 4'b1010, 4'b0000); #10;
      check_eq("iso_base", 32'(bus.oZ), 32'b1010);
      for (int k = 0; k < 6; k++) begin
         if (k % 3 == 0) bus.iC0 = (k < 3) ? 4'b1111 : 4'b0000;
         if (k % 3 == 1) bus.iC1 = (k < 3) ? 4'b1111 : 4'b0000;
         if (k % 3 == 2) bus.iC3 = (k < 3) ? 4'b1111 : 4'b0000;
         #10;
         check_eq("iso_toggle", 32'(bus.oZ), 32'b1010);
      end

      // Still in reset, no edges: registers stay clear.
      check_eq("reset_hold_ozr", 32'(bus.oZR), 32'h0);

      // Registered path: release reset with clock low, select 11 / C3 = 0110.
      drive(2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0110);
      #1;
      iRst   = 1'b0;
      clk_en = 1'b1;
      @(posedge iClk); #1;
      check_eq("first_edge_ozr", 32'(bus.oZR), 32'b0110);
      check_eq("first_edge_selchg", 32'(bus.oSelChg), 32'h1);
      @(posedge iClk); #1;
      check_eq("held_sel_selchg", 32'(bus.oSelChg), 32'h0);
      check_eq("held_sel_ozr", 32'(bus.oZR), 32'b0110);

      // Mid-operation reset between edges.
      #2;
      iRst = 1'b1;
      #1;
      check_eq("midrst_ozr", 32'(bus.oZR), 32'h0);
      check_eq("midrst_selchg", 32'(bus.oSelChg), 32'h0);
      check_eq("midrst_oz", 32'(bus.oZ), 32'b0110);

      // Release; first edge compares select 11 against reset value 00.
      @(negedge iClk);
      iRst = 1'b0;
      @(posedge iClk); #1;
      check_eq("rel_edge_ozr", 32'(bus.oZR), 32'b0110);
      check_eq("rel_edge_selchg", 32'(bus.oSelChg), 32'h1);
      prev_sel = 2'b11;

      // All selects x random data: oZ combinational, oZR one cycle later.
      for (int i = 0; i < 100; i++) begin
         @(negedge iClk);
         cur_sel = 2'(i % 4);
         for (int c = 0; c < 4; c++) chan[c] = 4'($urandom_range(0, 15));
         drive(cur_sel, chan[0], chan[1], chan[2], chan[3]);
         case (cur_sel)
            2'b00:   exp_z = chan[0];
            2'b01:   exp_z = chan[1];
            2'b10:   exp_z = chan[2];
            default: exp_z = chan[3];
         endcase
         exp_q.push_back(exp_z);
         #1;
         check_eq("rand_oz", 32'(bus.oZ), 32'(exp_z));
         @(posedge iClk); #1;
         exp_zr = exp_q.pop_front();
         check_eq("rand_ozr", 32'(bus.oZR), 32'(exp_zr));
         check_eq("rand_selchg", 32'(bus.oSelChg), 32'(cur_sel != prev_sel));
         prev_sel = cur_sel;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_selector_41
